// File: rtl/cla_seq_adder_pkg.sv
// Shared types and constants for the nibble-serial carry-lookahead adder.
// Imported by the top level and the lookahead slice.
package cla_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } cla_seq_state_t;

    localparam int NIB_W = 4;

endpackage

// File: rtl/nibble_cla.sv
// Purely combinational 4-bit carry-lookahead slice with fully expanded carries.
// It is reused once per clock by cla_seq_adder for each nibble in turn.
module nibble_cla
    import cla_pkg::*;
(
    input  logic [NIB_W-1:0] A,
    input  logic [NIB_W-1:0] B,
    input  logic             Cin,
    output logic [NIB_W-1:0] S,
    output logic             Cout
);

    logic [NIB_W-1:0] g_s;
    logic [NIB_W-1:0] p_s;
    logic [NIB_W:0]   c_s;

    assign g_s = A & B;
    assign p_s = A ^ B;

    // Every carry is a flat sum of products of g/p and Cin, with no ripple between bits.
    assign c_s[0] = Cin;
    assign c_s[1] = g_s[0] | (p_s[0] & Cin);
    assign c_s[2] = g_s[1] | (p_s[1] & g_s[0]) | (p_s[1] & p_s[0] & Cin);
    assign c_s[3] = g_s[2] | (p_s[2] & g_s[1]) | (p_s[2] & p_s[1] & g_s[0])
                  | (p_s[2] & p_s[1] & p_s[0] & Cin);
    assign c_s[4] = g_s[3] | (p_s[3] & g_s[2]) | (p_s[3] & p_s[2] & g_s[1])
                  | (p_s[3] & p_s[2] & p_s[1] & g_s[0])
                  | (p_s[3] & p_s[2] & p_s[1] & p_s[0] & Cin);

    assign S    = p_s ^ c_s[NIB_W-1:0];
    assign Cout = c_s[NIB_W];

endmodule

// File: rtl/cla_seq_adder.sv
// Sequential WIDTH-bit adder/subtractor: one shared 4-bit lookahead slice walks the
// operands a nibble per clock, linked by a registered carry, with valid/ready on both sides.
module cla_seq_adder
    import cla_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    localparam int NIB   = WIDTH / NIB_W;
    localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);
    localparam int MSB   = WIDTH - 1;

    cla_seq_state_t   state_r;
    logic [WIDTH-1:0] a_q_r;
    logic [WIDTH-1:0] b_q_r;
    logic             carry_r;
    logic [IDX_W-1:0] idx_r;
    logic [WIDTH-1:0] sum_r;
    logic             cout_r;
    logic             ovf_r;
    logic             out_valid_r;

    logic [NIB_W-1:0] a_nib_s;
    logic [NIB_W-1:0] b_nib_s;
    logic [NIB_W-1:0] slice_sum_s;
    logic             slice_cout_s;
    logic             ovf_s;

    assign a_nib_s = a_q_r[NIB_W*idx_r +: NIB_W];
    assign b_nib_s = b_q_r[NIB_W*idx_r +: NIB_W];

    nibble_cla u_slice (
        .A    (a_nib_s),
        .B    (b_nib_s),
        .Cin  (carry_r),
        .S    (slice_sum_s),
        .Cout (slice_cout_s)
    );

    // b_q already holds ~b in subtract mode, so one overflow rule covers add and subtract.
    assign ovf_s = (a_q_r[MSB] == b_q_r[MSB]) & (slice_sum_s[NIB_W-1] != a_q_r[MSB]);

    assign in_ready  = (state_r == IDLE);
    assign busy      = (state_r != IDLE);
    assign out_valid = out_valid_r;
    assign sum       = sum_r;
    assign cout      = cout_r;
    assign ovf       = ovf_r;

    // FSM with operand capture, nibble iteration and result hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            a_q_r       <= {WIDTH{1'b0}};
            b_q_r       <= {WIDTH{1'b0}};
            carry_r     <= 1'b0;
            idx_r       <= {IDX_W{1'b0}};
            sum_r       <= {WIDTH{1'b0}};
            cout_r      <= 1'b0;
            ovf_r       <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        a_q_r   <= a;
                        b_q_r   <= sub ? ~b : b;
                        carry_r <= sub ? 1'b1 : cin;
                        idx_r   <= {IDX_W{1'b0}};
                        sum_r   <= {WIDTH{1'b0}};
                        state_r <= RUN;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                RUN: begin
                    sum_r[NIB_W*idx_r +: NIB_W] <= slice_sum_s;
                    carry_r                     <= slice_cout_s;
                    if (idx_r == LAST_IDX) begin
                        idx_r       <= {IDX_W{1'b0}};
                        cout_r      <= slice_cout_s;
                        ovf_r       <= ovf_s;
                        out_valid_r <= 1'b1;
                        state_r     <= DONE;
                    end else begin
                        idx_r   <= idx_r + IDX_W'(1);
                        state_r <= RUN;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        state_r     <= IDLE;
                    end else begin
                        state_r <= DONE;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cla_seq_adder.sv
// Directed self-checking bench for cla_seq_adder (WIDTH=16) with hand-computed results.
module tb_cla_seq_adder;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    logic        busy;

    int checks;
    int errors;

    cla_seq_adder #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Waits for out_valid after an accept edge; returns cycles counted (99 on timeout).
    task automatic wait_result(output int lat);
        lat = 99;
        for (int n = 1; n <= 12; n++) begin
            @(posedge clk); #1;
            if (out_valid) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic consume();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check_val("consume_valid", 32'(out_valid), 32'd0);
        check_val("consume_ready", 32'(in_ready), 32'd1);
    endtask

    task automatic do_op(input string tag, input logic [15:0] av, input logic [15:0] bv,
                         input logic sv, input logic cv,
                         input logic [15:0] exp_sum, input logic exp_cout, input logic exp_ovf);
        int lat;
        @(negedge clk);
        check_val({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        a = av; b = bv; sub = sv; cin = cv; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = 16'hDEAD; b = 16'hBEEF; sub = ~sv; cin = ~cv;
        check_val({tag, "_busy"}, 32'(busy), 32'd1);
        wait_result(lat);
        check_val({tag, "_latency"}, 32'(lat), 32'd4);
        check_val({tag, "_sum"}, 32'(sum), 32'(exp_sum));
        check_val({tag, "_cout"}, 32'(cout), 32'(exp_cout));
        check_val({tag, "_ovf"}, 32'(ovf), 32'(exp_ovf));
        consume();
    endtask

    initial begin
        int lat;
        checks = 0; errors = 0;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = 16'h0000; b = 16'h0000; cin = 1'b0; sub = 1'b0;
        #23;
        rst_n = 1'b1;
        #1;
        check_val("rst_in_ready", 32'(in_ready), 32'd1);
        check_val("rst_out_valid", 32'(out_valid), 32'd0);
        check_val("rst_sum", 32'(sum), 32'd0);
        check_val("rst_cout", 32'(cout), 32'd0);
        check_val("rst_ovf", 32'(ovf), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);

        do_op("add",    16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
        do_op("ripple", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        do_op("ovfpos", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        do_op("ovfneg", 16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
        do_op("addcin", 16'h0001, 16'h0001, 1'b0, 1'b1, 16'h0003, 1'b0, 1'b0);
        do_op("sub5_7", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        do_op("sub7_5", 16'h0007, 16'h0005, 1'b1, 1'b0, 16'h0002, 1'b1, 1'b0);
        do_op("subovf", 16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1);

        // Backpressure: result held, new operands offered but not captured.
        @(negedge clk);
        a = 16'h1111; b = 16'h2222; sub = 1'b0; cin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_result(lat);
        check_val("bp_latency", 32'(lat), 32'd4);
        @(negedge clk);
        a = 16'hAAAA; b = 16'h1111; in_valid = 1'b1; out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check_val("bp_sum", 32'(sum), 32'h3333);
            check_val("bp_cout", 32'(cout), 32'd0);
            check_val("bp_ovf", 32'(ovf), 32'd0);
            check_val("bp_in_ready", 32'(in_ready), 32'd0);
            check_val("bp_out_valid", 32'(out_valid), 32'd1);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check_val("bp_idle_valid", 32'(out_valid), 32'd0);
        check_val("bp_idle_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check_val("bp_accept_busy", 32'(busy), 32'd1);
        wait_result(lat);
        check_val("bp_new_latency", 32'(lat), 32'd4);
        check_val("bp_new_sum", 32'(sum), 32'hBBBB);
        consume();

        // Reset after two RUN cycles abandons the operation.
        @(negedge clk);
        a = 16'hFFFF; b = 16'hFFFF; sub = 1'b0; cin = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check_val("mid_rst_valid", 32'(out_valid), 32'd0);
        check_val("mid_rst_sum", 32'(sum), 32'd0);
        check_val("mid_rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_val("post_rst_ready", 32'(in_ready), 32'd1);
        do_op("post_rst", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cla_seq_adder.md
# cla_seq_adder

Sequential wide adder/subtractor. It reuses a single 4-bit carry-lookahead slice over successive nibbles of WIDTH-bit operands, one nibble per clock. A registered carry links adjacent nibbles. The block sits between an operand producer and a result consumer, with valid/ready handshakes on both sides, and trades latency for area in wide arithmetic paths.

## Interface
- WIDTH, 16, operand/result width; must be a multiple of 4 and at least 8
- NIB (derived, not overridable), WIDTH/4, nibble count
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand transfer request
- in_ready  output  1  block idle and able to accept operands
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry-in; add mode only, ignored when sub=1
- sub  input  1  1 computes A-B, 0 computes A+B+cin
- out_valid  output  1  result registers hold a valid result
- out_ready  input  1  consumer accepts the result
- sum  output  WIDTH  result
- cout  output  1  carry out of the MSB; in subtract mode, 1 means no borrow
- ovf  output  1  two's-complement signed overflow
- busy  output  1  1 in RUN or DONE

## Operation
- FSM states: IDLE, RUN, DONE.
- **IDLE**
  - in_ready=1.
  - Operands are accepted on the edge where in_valid & in_ready.
  - On acceptance: a_q<=a; b_q<=sub ? ~b : b; carry<=sub ? 1 : cin; idx<=0; sum<=0; move to RUN.
- **RUN**
  - One nibble per cycle: the slice adds a_q[4*idx+:4], b_q[4*idx+:4] and carry.
  - Each edge: sum[4*idx+:4]<=slice sum; carry<=slice cout; idx<=idx+1.
  - On the edge where idx==NIB-1:
    - cout<=slice cout.
    - ovf<=(a_q[MSB]==b_q[MSB]) & (slice sum bit 3 != a_q[MSB]).
    - out_valid<=1; move to DONE.
  - in_ready=0.
- **DONE**
  - sum, cout and ovf are held stable while out_valid=1.
  - On out_valid & out_ready: out_valid<=0; move to IDLE.
  - in_ready=0, so a new operand is never accepted in the same cycle a result is consumed.
- Arithmetic is modulo 2^WIDTH. idx is ceil(log2(NIB)) bits wide and never exceeds NIB-1.
- Inputs are sampled only at the acceptance edge. Changes to a, b, sub or cin while busy have no effect.
- in_valid while busy is ignored. It is not queued, and the producer holds it under standard valid/ready rules.
- out_ready is ignored when out_valid=0.

## Timing
- Reset values (asynchronous, applied immediately on rst_n low):
  - state=IDLE, so in_ready=1 once rst_n is high.
  - out_valid=0, sum=0, cout=0, ovf=0, busy=0.
  - idx=0, carry=0, a_q=0, b_q=0.
- Latency: operands accepted at edge E0 give out_valid=1 after edge E0+NIB (4 cycles for WIDTH=16).
- Throughput: at best one operation per NIB+2 cycles (accept, NIB RUN cycles, consume).
- Reset mid-RUN or mid-DONE: the operation is abandoned and the result is never presented. The block returns to IDLE with all outputs at reset values.
- in_ready, busy and out_valid are decoded from registered state only. None is combinationally dependent on in_valid or out_ready.
- The carry chain is confined to one 4-bit slice per cycle, so there is no WIDTH-length combinational path.

## Structure
- Shared package cla_pkg holds:
  - typedef enum logic [1:0] {IDLE, RUN, DONE} cla_seq_state_t
  - localparam NIB_W=4
- One sub-module, nibble_cla: a purely combinational 4-bit carry-lookahead slice.
  - Ports: A[3:0], B[3:0], Cin, S[3:0], Cout.
  - Generate/propagate terms with fully expanded lookahead carries.
  - Instantiated once and muxed by idx.
- The top level holds the FSM, operand and result registers, carry register, nibble mux and overflow logic.

## Test plan
- **Basic add:** WIDTH=16, a=0x1234, b=0x4321, sub=0, cin=0.
  - Expect sum=0x5555, cout=0, ovf=0.
  - out_valid rises exactly 4 cycles after the accept edge.
- **Full carry ripple:** a=0xFFFF, b=0x0001, cin=0.
  - Expect sum=0x0000, cout=1, ovf=0.
  - The carry propagates through all four nibble iterations.
- **Signed overflow:**
  - a=0x7FFF, b=0x0001: expect sum=0x8000, ovf=1, cout=0.
  - a=0x8000, b=0x8000: expect sum=0x0000, ovf=1, cout=1.
- **Subtract:**
  - a=0x0005, b=0x0007, sub=1, cin=1: cin is ignored; expect sum=0xFFFE, cout=0, ovf=0.
  - a=0x0007, b=0x0005: expect sum=0x0002, cout=1.
- **Backpressure:** hold out_ready=0 for 3 cycles after out_valid, with in_valid=1 and new operands driven.
  - sum, cout and ovf stay stable; in_ready=0; the new operands are not captured.
  - After out_ready=1: IDLE next cycle, then the new operands are accepted.
- **Reset mid-RUN:** drop rst_n after 2 RUN cycles.
  - Immediately: out_valid=0, sum=0, busy=0.
  - After release: in_ready=1, and a fresh 0x1234+0x4321 returns 0x5555.
